// File: rtl/dmem_block_responder.sv
// Block fill/writeback responder over a word-organised backing store.
// Ports: CLK, RESET (sync, active-low), bread/bwrite/address/block_in in;
//        block_out, rvalid, wdone, busy, ovf out.
module dmem_block_responder #(
  parameter int DATA = 32,
  parameter int ADDR = 32,
  parameter int OFST = 5,
  parameter int BLCK = 8 << OFST,
  parameter int MEMW = 10,
  parameter int LAT  = 4
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            bread,
  input  logic            bwrite,
  input  logic [ADDR-1:0] address,
  input  logic [BLCK-1:0] block_in,
  output logic [BLCK-1:0] block_out,
  output logic            rvalid,
  output logic            wdone,
  output logic            busy,
  output logic            ovf
);

  localparam int WPB = BLCK / DATA;
  localparam int BW  = OFST - 2;
  localparam logic [BW-1:0] LAST = BW'(WPB - 1);
  localparam logic [3:0]    LATV = 4'(LAT);

  typedef enum logic [2:0] {
    IDLE, WAIT, RBEAT, WBEAT, RESP
  } state_t;

  state_t state, state_n, go_st;

  logic            op;
  logic [MEMW-1:0] wbase;
  logic [BLCK-1:0] wblk;
  logic [3:0]      lcnt;
  logic [BW-1:0]   beat;

  logic            pend_v, pend_op;
  logic [MEMW-1:0] pend_base;
  logic [BLCK-1:0] pend_blk;

  logic [DATA-1:0] mem [2**MEMW];

  logic            ld, ld_op;
  logic [MEMW-1:0] ld_base;
  logic [BLCK-1:0] ld_blk;
  logic            push, push_op;
  logic [MEMW-1:0] push_base;
  logic [BLCK-1:0] push_blk;
  logic            pclr, drop, free, slot_free;
  logic [MEMW-1:0] in_base;
  logic [MEMW-1:0] waddr;

  logic unused_addr;
  assign unused_addr = ^{address[ADDR-1:MEMW+2], address[OFST-1:0]};

  assign in_base = {address[MEMW+1:OFST], BW'(0)};
  assign waddr   = wbase + MEMW'(beat);

  // The FSM is free to start a fresh request in IDLE, or in RESP when
  // nothing is queued; otherwise arrivals go to the single pending slot,
  // which is vacated in RESP as its request is loaded.
  always_comb begin
    ld        = 1'b0;
    ld_op     = 1'b0;
    ld_base   = '0;
    ld_blk    = '0;
    push      = 1'b0;
    push_op   = 1'b0;
    push_base = '0;
    push_blk  = '0;
    pclr      = 1'b0;
    drop      = 1'b0;
    free      = (state == IDLE) || (state == RESP && !pend_v);
    slot_free = !pend_v || (state == RESP);
    if (free) begin
      if (bwrite) begin
        ld      = 1'b1;
        ld_op   = 1'b1;
        ld_base = in_base;
        ld_blk  = block_in;
        if (bread) begin
          push      = 1'b1;
          push_base = in_base;
        end
      end else if (bread) begin
        ld      = 1'b1;
        ld_base = in_base;
      end
    end else begin
      if (state == RESP) begin
        ld      = 1'b1;
        ld_op   = pend_op;
        ld_base = pend_base;
        ld_blk  = pend_blk;
        pclr    = 1'b1;
      end
      if (bwrite || bread) begin
        if (slot_free) begin
          push      = 1'b1;
          push_op   = bwrite;
          push_base = in_base;
          push_blk  = block_in;
          drop      = bwrite && bread;
        end else begin
          drop = 1'b1;
        end
      end
    end
  end

  always_comb begin
    go_st   = WAIT;
    state_n = state;
    if (LATV == 4'd0) go_st = ld_op ? WBEAT : RBEAT;
    case (state)
      IDLE:  if (ld) state_n = go_st;
      WAIT:  if (lcnt == LATV - 4'd1)
               state_n = op ? WBEAT : RBEAT;
      RBEAT: if (beat == LAST) state_n = RESP;
      WBEAT: if (beat == LAST) state_n = RESP;
      RESP:  state_n = ld ? go_st : IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state     <= IDLE;
      op        <= 1'b0;
      wbase     <= '0;
      wblk      <= '0;
      lcnt      <= '0;
      beat      <= '0;
      pend_v    <= 1'b0;
      pend_op   <= 1'b0;
      pend_base <= '0;
      pend_blk  <= '0;
      block_out <= '0;
      ovf       <= 1'b0;
    end else begin
      state <= state_n;
      if (state == WAIT) lcnt <= lcnt + 4'd1;
      if (state == RBEAT || state == WBEAT)
        beat <= beat + 1'b1;
      if (state == RBEAT)
        block_out[int'(beat)*DATA +: DATA] <= mem[waddr];
      if (ld) begin
        op    <= ld_op;
        wbase <= ld_base;
        wblk  <= ld_blk;
        lcnt  <= '0;
        beat  <= '0;
      end
      if (push) begin
        pend_v    <= 1'b1;
        pend_op   <= push_op;
        pend_base <= push_base;
        pend_blk  <= push_blk;
      end else if (pclr) begin
        pend_v <= 1'b0;
      end
      if (drop) ovf <= 1'b1;
    end
  end

  // Store is not reset; reset only stops further beats.
  always_ff @(posedge CLK) begin
    if (RESET && state == WBEAT)
      mem[waddr] <= wblk[int'(beat)*DATA +: DATA];
  end

  assign rvalid = (state == RESP) && !op;
  assign wdone  = (state == RESP) && op;
  assign busy   = (state != IDLE) || pend_v;

endmodule

// File: tb/tb_dmem_block_responder.sv
// Self-checking bench for dmem_block_responder (latency 4 and latency 0).
// Strobes are scored against a queue of expected {kind, cycle, block}.
module tb_dmem_block_responder;

  logic CLK = 1'b0;
  logic RESET = 1'b0;
  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  logic         bread_a = 0, bwrite_a = 0;
  logic [31:0]  addr_a = 0;
  logic [255:0] bin_a = 0, bout_a;
  logic         rv_a, wd_a, busy_a, ovf_a;

  logic         bread_b = 0, bwrite_b = 0;
  logic [31:0]  addr_b = 0;
  logic [255:0] bin_b = 0, bout_b;
  logic         rv_b, wd_b, busy_b, ovf_b;

  dmem_block_responder #(.LAT(4)) dut_a (
    .CLK(CLK), .RESET(RESET), .bread(bread_a), .bwrite(bwrite_a),
    .address(addr_a), .block_in(bin_a), .block_out(bout_a),
    .rvalid(rv_a), .wdone(wd_a), .busy(busy_a), .ovf(ovf_a)
  );

  dmem_block_responder #(.LAT(0)) dut_b (
    .CLK(CLK), .RESET(RESET), .bread(bread_b), .bwrite(bwrite_b),
    .address(addr_b), .block_in(bin_b), .block_out(bout_b),
    .rvalid(rv_b), .wdone(wd_b), .busy(busy_b), .ovf(ovf_b)
  );

  typedef struct {
    bit           wr;
    int           cyc;
    logic [255:0] blk;
  } exp_t;

  typedef struct {
    bit          b;
    bit          wr;
    logic [31:0] a;
    logic [31:0] v0;
  } vec_t;

  exp_t qa[$], qb[$];
  exp_t ea, eb;
  logic [31:0] ma [1024];
  logic [31:0] mb [1024];
  int pass_n = 0, tot_n = 0;

  task automatic chk(input string nm, input logic [255:0] act,
                     input logic [255:0] req);
    tot_n++;
    if (act === req) pass_n++;
    else $display("FAIL %s: got %h want %h", nm, act, req);
  endtask

  function automatic logic [9:0] wb(input logic [31:0] a);
    return {a[11:5], 3'b000};
  endfunction

  function automatic logic [255:0] mkblk(input logic [31:0] v0);
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = v0 + 32'(i);
    return r;
  endfunction

  function automatic logic [255:0] rd_model(input bit b,
                                            input logic [9:0] base);
    logic [255:0] r;
    for (int i = 0; i < 8; i++)
      r[i*32 +: 32] = b ? mb[base + 10'(i)] : ma[base + 10'(i)];
    return r;
  endfunction

  task automatic wr_model(input bit b, input logic [9:0] base,
                          input logic [255:0] blk, input int n);
    for (int i = 0; i < n; i++)
      if (b) mb[base + 10'(i)] = blk[i*32 +: 32];
      else   ma[base + 10'(i)] = blk[i*32 +: 32];
  endtask

  always @(negedge CLK) begin
    if (rv_a || wd_a) begin
      if (qa.size() == 0) begin
        tot_n++;
        $display("FAIL a_strobe: unexpected rvalid=%b wdone=%b cycle %0d",
                 rv_a, wd_a, cyc);
      end else begin
        ea = qa.pop_front();
        chk("a_strobe_cycle", 256'(cyc), 256'(ea.cyc));
        chk("a_strobe_kind", {rv_a, wd_a}, {~ea.wr, ea.wr});
        if (!ea.wr) chk("a_block", bout_a, ea.blk);
      end
    end
  end

  always @(negedge CLK) begin
    if (rv_b || wd_b) begin
      if (qb.size() == 0) begin
        tot_n++;
        $display("FAIL b_strobe: unexpected rvalid=%b wdone=%b cycle %0d",
                 rv_b, wd_b, cyc);
      end else begin
        eb = qb.pop_front();
        chk("b_strobe_cycle", 256'(cyc), 256'(eb.cyc));
        chk("b_strobe_kind", {rv_b, wd_b}, {~eb.wr, eb.wr});
        if (!eb.wr) chk("b_block", bout_b, eb.blk);
      end
    end
  end

  task automatic req(input bit b, input bit w, input bit r,
                     input logic [31:0] a, input logic [255:0] blk,
                     output int c0);
    @(negedge CLK);
    if (b) begin
      bwrite_b = w; bread_b = r; addr_b = a; bin_b = blk;
    end else begin
      bwrite_a = w; bread_a = r; addr_a = a; bin_a = blk;
    end
    c0 = cyc;
    @(posedge CLK);
    #1;
    bwrite_a = 0; bread_a = 0;
    bwrite_b = 0; bread_b = 0;
  endtask

  task automatic issue(input bit b, input bit w, input bit r,
                       input logic [31:0] a, input logic [31:0] v0);
    int c0;
    int l;
    exp_t e;
    logic [255:0] blk;
    l = b ? 9 : 13;
    blk = mkblk(v0);
    req(b, w, r, a, blk, c0);
    if (w) begin
      wr_model(b, wb(a), blk, 8);
      e = '{1'b1, c0 + l, blk};
      if (b) qb.push_back(e); else qa.push_back(e);
    end
    if (r) begin
      e = '{1'b0, c0 + (w ? 2*l : l), rd_model(b, wb(a))};
      if (b) qb.push_back(e); else qa.push_back(e);
    end
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 300; i++) begin
      @(negedge CLK);
      if (qa.size() == 0 && qb.size() == 0 && !busy_a && !busy_b)
        return;
    end
    tot_n++;
    $display("FAIL idle_timeout: pending a=%0d b=%0d want 0",
             qa.size(), qb.size());
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached, want finish");
    $fatal(1);
  end

  vec_t vt[8];
  int c0, c1, c2;

  initial begin
    vt[0] = '{1'b0, 1'b1, 32'h40,   32'hA000_0010};
    vt[1] = '{1'b0, 1'b1, 32'hC0,   32'hA000_0030};
    vt[2] = '{1'b0, 1'b0, 32'h40,   32'h0};
    vt[3] = '{1'b0, 1'b1, 32'h80,   32'h5500_0000};
    vt[4] = '{1'b0, 1'b0, 32'h80,   32'h0};
    vt[5] = '{1'b1, 1'b1, 32'hFE0,  32'hA000_03F8};
    vt[6] = '{1'b1, 1'b0, 32'hFE0,  32'h0};
    vt[7] = '{1'b1, 1'b0, 32'h1FE0, 32'h0};

    RESET = 0;
    repeat (2) @(negedge CLK);
    chk("a_reset_outs", {rv_a, wd_a, busy_a, ovf_a}, 4'b0);
    chk("a_reset_block", bout_a, '0);
    chk("b_reset_outs", {rv_b, wd_b, busy_b, ovf_b}, 4'b0);
    chk("b_reset_block", bout_b, '0);
    RESET = 1;

    for (int i = 0; i < 8; i++) begin
      issue(vt[i].b, vt[i].wr, !vt[i].wr, vt[i].a, vt[i].v0);
      wait_idle();
    end
    chk("a_ovf_clean", ovf_a, 1'b0);
    chk("b_ovf_clean", ovf_b, 1'b0);

    // busy profile of a plain read
    issue(0, 0, 1, 32'h40, 32'h0);
    for (int k = 1; k <= 14; k++) begin
      @(negedge CLK);
      chk($sformatf("busy_c%0d", k), busy_a, (k <= 13));
    end
    wait_idle();

    // simultaneous write + read through the pending slot
    issue(0, 1, 1, 32'h80, 32'h6600_0000);
    wait_idle();
    chk("pair_ovf", ovf_a, 1'b0);

    // three requests in one operation: second served, third dropped
    req(0, 0, 1, 32'h40, '0, c0);
    qa.push_back('{1'b0, c0 + 13, rd_model(0, wb(32'h40))});
    req(0, 0, 1, 32'hC0, '0, c1);
    qa.push_back('{1'b0, c0 + 26, rd_model(0, wb(32'hC0))});
    req(0, 1, 0, 32'h80, mkblk(32'h9900_0000), c2);
    wait_idle();
    chk("drop_ovf", ovf_a, 1'b1);
    issue(0, 0, 1, 32'h80, 32'h0);
    wait_idle();
    chk("ovf_sticky", ovf_a, 1'b1);

    // reset in cycle 9 of a write: four words land, the rest do not
    req(0, 1, 0, 32'hC0, mkblk(32'h7700_0000), c0);
    repeat (8) @(negedge CLK);
    chk("ovf_before_rst", ovf_a, 1'b1);
    @(negedge CLK);
    RESET = 0;
    @(negedge CLK);
    chk("a_abort_outs", {rv_a, wd_a, busy_a, ovf_a}, 4'b0);
    chk("a_abort_block", bout_a, '0);
    RESET = 1;
    wr_model(0, wb(32'hC0), mkblk(32'h7700_0000), 4);
    issue(0, 0, 1, 32'hC0, 32'h0);
    wait_idle();
    chk("ovf_after_rst", ovf_a, 1'b0);

    $display("%0d/%0d checks passed", pass_n, tot_n);
    $finish;
  end

endmodule
